// File: rtl/ex_muldiv_if.sv
// rtl/ex_muldiv_if.sv - EX-stage multiply/divide unit bus (request, HI/LO write, status)
interface ex_muldiv_if;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Flush;
  logic        MtHi;
  logic        MtLo;
  logic [31:0] MtData;
  logic        Busy;
  logic        Done;
  logic [31:0] Hi;
  logic [31:0] Lo;

  modport master (
    output Start, Op, A, B, Flush, MtHi, MtLo, MtData,
    input  Busy, Done, Hi, Lo
  );

  modport slave (
    input  Start, Op, A, B, Flush, MtHi, MtLo, MtData,
    output Busy, Done, Hi, Lo
  );
endinterface

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative MULT/MULTU (and DIV/DIVU when MULDIV_DIV_EN is defined) with HI/LO
module ex_muldiv (
  input  logic         Clk,
  input  logic         Reset,
  ex_muldiv_if.slave   bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
`ifdef MULDIV_DIV_EN
  localparam logic [1:0] S_DIV  = 2'd2;
`endif
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  r_state;
  logic [5:0]  r_cnt;
  // Multiplicand for MULT, divisor for DIV (always a magnitude).
  logic [31:0] r_a;
  // Low half starts as multiplier / dividend magnitude, high half is the
  // running partial product / partial remainder.
  logic [63:0] r_acc;
  logic        r_neg;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
`ifdef MULDIV_DIV_EN
  logic        r_neg_rem;
`endif

  logic        w_open;
  logic        w_op_ok;
  logic        w_accept;
  logic        w_last;
  logic        w_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_next;
  logic [63:0] w_mul_res;

  assign w_open   = (r_state == S_IDLE) || (r_state == S_DONE);
`ifdef MULDIV_DIV_EN
  assign w_op_ok  = 1'b1;
`else
  // Without the divider a DIV/DIVU request is simply not taken.
  assign w_op_ok  = ~bus.Op[1];
`endif
  assign w_accept = w_open & bus.Start & ~bus.Flush & w_op_ok;
  assign w_last   = (r_cnt == 6'd31);

  assign w_signed = ~bus.Op[0];
  assign w_a_neg  = w_signed & bus.A[31];
  assign w_b_neg  = w_signed & bus.B[31];
  assign w_abs_a  = w_a_neg ? (32'd0 - bus.A) : bus.A;
  assign w_abs_b  = w_b_neg ? (32'd0 - bus.B) : bus.B;

  // Shift-add step: conditionally add multiplicand to the top half, then shift right.
  assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_a} : 33'd0);
  assign w_mul_next = {w_mul_sum, r_acc[31:1]};
  assign w_mul_res  = r_neg ? (64'd0 - w_mul_next) : w_mul_next;

`ifdef MULDIV_DIV_EN
  logic [32:0] w_rem_sh;
  logic        w_ge;
  logic [31:0] w_diff;
  logic [63:0] w_div_next;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  // Restoring step: shift in next dividend bit, subtract divisor if it fits.
  // A zero divisor always "fits", giving all-ones quotient and remainder = dividend.
  assign w_rem_sh   = r_acc[63:31];
  assign w_ge       = (w_rem_sh >= {1'b0, r_a});
  assign w_diff     = w_rem_sh[31:0] - r_a;
  assign w_div_next = {(w_ge ? w_diff : w_rem_sh[31:0]), r_acc[30:0], w_ge};
  assign w_quo      = w_div_next[31:0];
  assign w_rem      = w_div_next[63:32];

  assign bus.Busy = (r_state == S_MUL) || (r_state == S_DIV);
`else
  assign bus.Busy = (r_state == S_MUL);
`endif
  assign bus.Done = (r_state == S_DONE);
  assign bus.Hi   = r_hi;
  assign bus.Lo   = r_lo;

  // Control FSM and iteration counter.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 6'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_cnt <= 6'd0;
          if (w_accept) begin
`ifdef MULDIV_DIV_EN
            r_state <= bus.Op[1] ? S_DIV : S_MUL;
`else
            r_state <= S_MUL;
`endif
          end else begin
            r_state <= S_IDLE;
          end
        end
`ifdef MULDIV_DIV_EN
        S_MUL, S_DIV: begin
`else
        S_MUL: begin
`endif
          if (bus.Flush) begin
            r_state <= S_IDLE;
            r_cnt   <= 6'd0;
          end else if (w_last) begin
            r_state <= S_DONE;
            r_cnt   <= 6'd0;
          end else begin
            r_cnt   <= r_cnt + 6'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 6'd0;
        end
      endcase
    end
  end

  // Operand latch, iteration datapath and architectural HI/LO.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_a       <= 32'd0;
      r_acc     <= 64'd0;
      r_neg     <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
`ifdef MULDIV_DIV_EN
      r_neg_rem <= 1'b0;
`endif
    end else if (w_accept) begin
`ifdef MULDIV_DIV_EN
      r_a       <= bus.Op[1] ? w_abs_b : w_abs_a;
      r_acc     <= {32'd0, (bus.Op[1] ? w_abs_a : w_abs_b)};
      // Divide-by-zero keeps the all-ones quotient unnegated.
      r_neg     <= (w_a_neg ^ w_b_neg) & ~(bus.Op[1] & (bus.B == 32'd0));
      r_neg_rem <= w_a_neg;
`else
      r_a       <= w_abs_a;
      r_acc     <= {32'd0, w_abs_b};
      r_neg     <= w_a_neg ^ w_b_neg;
`endif
    end else if ((r_state == S_MUL) && !bus.Flush) begin
      r_acc <= w_mul_next;
      if (w_last) begin
        r_hi <= w_mul_res[63:32];
        r_lo <= w_mul_res[31:0];
      end
`ifdef MULDIV_DIV_EN
    end else if ((r_state == S_DIV) && !bus.Flush) begin
      r_acc <= w_div_next;
      if (w_last) begin
        r_lo <= r_neg ? (32'd0 - w_quo) : w_quo;
        r_hi <= r_neg_rem ? (32'd0 - w_rem) : w_rem;
      end
`endif
    end else if (w_open) begin
      if (bus.MtHi) r_hi <= bus.MtData;
      if (bus.MtLo) r_lo <= bus.MtData;
    end
  end

endmodule
